// File: rtl/regfile_tagged.sv
// Integer register file for the out-of-order core. NREAD combinational read ports,
// one commit write port with write-to-read bypass, and per-register busy bit and rename tag.
module regfile_tagged #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int TAG_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    cm_we,
    input  logic [ADDR_W-1:0]       cm_addr,
    input  logic [TAG_W-1:0]        cm_tag,
    input  logic [DATA_W-1:0]       cm_data,
    input  logic                    is_we,
    input  logic [ADDR_W-1:0]       is_addr,
    input  logic [TAG_W-1:0]        is_tag,
    input  logic                    flush,
    input  logic [NREAD-1:0]        re,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rbusy,
    output logic [NREAD*TAG_W-1:0]  rtag
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [TAG_W-1:0]  r_tag  [DEPTH];

    logic w_cm_fire;
    logic w_is_fire;
    logic w_flush;
    logic w_cm_clear;

    assign w_cm_fire  = rdy && cm_we && (cm_addr != '0);
    assign w_flush    = rdy && flush;
    assign w_is_fire  = rdy && is_we && (is_addr != '0) && !flush;
    // Only the producer that still owns the register may release it.
    assign w_cm_clear = w_cm_fire && r_busy[cm_addr] && (r_tag[cm_addr] == cm_tag);

    // NOTE: the storage array sits inside the async reset on purpose; reset must
    // leave every register architecturally zero, not just the busy bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_busy <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every update based on pre-edge state.
            if (w_cm_fire) begin
                r_regs[cm_addr] <= cm_data;
            end
            // Priority per entry: flush, then issue (a younger producer), then commit release.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_flush) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end else if (w_is_fire && (is_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= is_tag;
                end else if (w_cm_clear && (cm_addr == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_data;
        logic              w_bsy;
        logic [TAG_W-1:0]  w_tg;

        assign w_a = raddr[p*ADDR_W +: ADDR_W];

        // NOTE: every output gets a default first so no path can infer a latch.
        always_comb begin
            w_data = '0;
            w_bsy  = 1'b0;
            w_tg   = '0;
            if (!rst && re[p] && (w_a != '0)) begin
                if (w_cm_fire && (cm_addr == w_a)) begin
                    w_data = cm_data;
                    w_bsy  = r_busy[w_a] && !w_cm_clear;
                end else begin
                    w_data = r_regs[w_a];
                    w_bsy  = r_busy[w_a];
                end
                w_tg = w_bsy ? r_tag[w_a] : '0;
            end
        end

        assign rdata[p*DATA_W +: DATA_W] = w_data;
        assign rbusy[p]                  = w_bsy;
        assign rtag[p*TAG_W +: TAG_W]    = w_tg;
    end

endmodule

// File: doc/regfile_tagged.md
Name: regfile_tagged

Overview:
- Parametrised successor to the scalar integer register file, for the out-of-order core.
- Provides NREAD combinational read ports and one commit write port with write-to-read bypass.
- Adds a per-register busy bit plus rename tag (ROB index), set at issue and cleared at commit when the tag matches.
- Sits between the dispatch stage (issue/rename, operand read) and the commit stage (architectural write); flush support for branch mispredict.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)
TAG_W, 3, rename tag width (ROB index)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rdy  in  1  1 = advance; 0 = pause, no state change
cm_we  in  1  commit write enable
cm_addr  in  ADDR_W  commit destination register
cm_tag  in  TAG_W  ROB tag of committing instruction
cm_data  in  DATA_W  commit write data
is_we  in  1  issue/rename enable
is_addr  in  ADDR_W  destination register being renamed
is_tag  in  TAG_W  tag assigned to new producer
flush  in  1  clear all busy bits (mispredict)
re  in  NREAD  per-port read enable
raddr  in  NREAD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  read data per port
rbusy  out  NREAD  1 = operand pending, use rtag
rtag  out  NREAD*TAG_W  producer tag when rbusy=1, else 0

Behaviour:
- Reset (async, rst=1): all regs[*]=0, busy[*]=0, tag[*]=0. While rst=1, all outputs are 0 regardless of the other inputs.
- Register 0:
  - Writes and issues to address 0 are ignored.
  - Reads of address 0 return data 0, rbusy 0, rtag 0.
- Commit, at posedge with rdy=1, cm_we=1, cm_addr!=0:
  - regs[cm_addr] <= cm_data always.
  - busy[cm_addr] <= 0 only if busy[cm_addr]=1 and tag[cm_addr]==cm_tag. A younger producer keeps the register busy.
- Issue, at posedge with rdy=1, is_we=1, is_addr!=0: busy[is_addr] <= 1, tag[is_addr] <= is_tag.
- Flush, at posedge with rdy=1, flush=1:
  - All busy <= 0 and all tag <= 0.
  - A same-cycle issue is discarded.
  - A same-cycle commit data write still occurs.
- Same cycle, commit and issue to the same register with tags matching: issue wins, busy=1, tag=is_tag, data written.
- rdy=0: no architectural, busy or tag state changes. Read ports remain combinationally valid.
- Read port i, combinational, zero latency; priority order:
  1. rst=1 or re[i]=0 -> all zero.
  2. raddr==0 -> all zero.
  3. Bypass: cm_we=1, rdy=1, cm_addr==raddr -> rdata=cm_data. rbusy=0 if the commit clears busy per the rule above, otherwise the stored busy and tag are shown.
  4. Otherwise -> regs, busy, tag of raddr.
- Same-cycle issue does NOT affect read outputs. Dispatch handles intra-bundle dependencies itself; the renamed state is visible from the next cycle.
- Tag wrap: tags are compared by equality only; there is no age ordering inside this block.
- Ports are independent; any number may read the same address simultaneously with identical results.

Test Plan:
- Reset then read: assert rst mid-run with non-zero contents -> outputs 0 immediately (asynchronous). After release, reading x5 on both ports -> rdata=0, rbusy=0.
- Commit bypass: cm_we=1, cm_addr=7, cm_data=0xDEADBEEF, raddr0=7 same cycle -> rdata0=0xDEADBEEF combinationally. Next cycle, with no commit, rdata0 still 0xDEADBEEF.
- Rename/commit match:
  - Issue x3 with tag 2 -> next cycle rbusy=1, rtag=2.
  - Commit x3 with tag 2, data 0x55 -> same cycle rbusy=0, rdata=0x55; state stays clear afterwards.
- Stale commit: issue x3 tag 2, then issue x3 tag 5, then commit x3 tag 2, data 0x11 -> regs[3]=0x11 but rbusy stays 1, rtag=5. Commit x3 tag 5 then clears busy.
- Flush/x0/pause:
  - Issue x4 tag 1 and flush in the same cycle -> x4 not busy.
  - Commit to x0 with 0xFFFF -> reads of x0 return 0.
  - rdy=0 with commit x9 = 0x77 -> x9 unchanged after the edge.
- Simultaneous commit and issue to x6 (commit tag 1 matching, issue tag 4, data 0x99) -> after the edge regs[6]=0x99, rbusy=1, rtag=4. Run with NREAD=4, all ports reading x6 -> identical outputs on all ports.
